// File: rtl/knn_mem_responder_if.sv
// knn_mem_responder_if
//   Memory port between the KNN coprocessor (master) and its dataset
//   responder (slave).
//   mem_valid/mem_write/mem_addr/mem_wdata : request, driven by the master
//   mem_ready/mem_rdata                    : response, driven by the slave
interface knn_mem_responder_if;
   logic        mem_valid;
   logic        mem_write;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ready;
   logic [31:0] mem_rdata;

   modport master (
      output mem_valid, mem_write, mem_addr, mem_wdata,
      input  mem_ready, mem_rdata
   );

   modport slave (
      input  mem_valid, mem_write, mem_addr, mem_wdata,
      output mem_ready, mem_rdata
   );
endinterface

// File: rtl/knn_mem_responder.sv
// knn_mem_responder
//   Dataset store behind the KNN coprocessor memory port. Every cycle with
//   mem_valid high is a request; each request produces a one-cycle mem_ready
//   pulse exactly LATENCY cycles later, in order, fully pipelined. A
//   secondary load port preloads the array when the memory port is idle.
// Ports
//   clk, reset              : clock, synchronous active-high reset
//   mem (slave)             : coprocessor request/response bus
//   load_valid/addr/wdata   : preload write request
//   load_ready              : load accepted this cycle (combinational)
//   err_range, err_align    : sticky address error flags (both ports)
//   rd_count, wr_count      : accepted memory-port reads / writes
// LATENCY is legal from 1 to 4. Array contents survive reset.
module knn_mem_responder #(
   parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
   parameter int          DEPTH_WORDS = 4096,
   parameter int          LATENCY     = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   knn_mem_responder_if.slave         mem,
   input  logic                       load_valid,
   input  logic [31:0]                load_addr,
   input  logic [31:0]                load_wdata,
   output logic                       load_ready,
   output logic                       err_range,
   output logic                       err_align,
   output logic [31:0]                rd_count,
   output logic [31:0]                wr_count
);

   localparam int AW   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int LAST = LATENCY - 1;

   logic [31:0] ram_reg [DEPTH_WORDS];

   // Address decode for both ports. The subtraction wraps for addresses
   // below BASE_ADDR, so that case is caught by its own compare.
   logic [31:0]   mem_off;
   logic [31:0]   load_off;
   logic          mem_oor;
   logic          load_oor;
   logic [AW-1:0] mem_idx;
   logic [AW-1:0] load_idx;

   assign mem_off  = mem.mem_addr - BASE_ADDR;
   assign load_off = load_addr - BASE_ADDR;
   assign mem_oor  = (mem.mem_addr < BASE_ADDR) ||
                     ({2'b00, mem_off[31:2]} >= 32'(DEPTH_WORDS));
   assign load_oor = (load_addr < BASE_ADDR) ||
                     ({2'b00, load_off[31:2]} >= 32'(DEPTH_WORDS));
   assign mem_idx  = mem_off[AW+1:2];
   assign load_idx = load_off[AW+1:2];

   // The memory port never stalls, so the load port only gets idle cycles.
   assign load_ready = load_valid & ~mem.mem_valid & ~reset;

   logic mem_accept;
   assign mem_accept = mem.mem_valid & ~reset;

   // Response pipeline control: stage 0 is loaded in the acceptance cycle,
   // stage LAST drives the response.
   logic [LATENCY-1:0] pipe_valid_reg;
   logic [LATENCY-1:0] pipe_read_reg;
   logic [LATENCY-1:0] pipe_zero_reg;
   logic [31:0]        pipe_data_reg [LATENCY];
   logic [31:0]        rdata_hold_reg;
   logic               err_range_reg;
   logic               err_align_reg;
   logic [31:0]        rd_count_reg;
   logic [31:0]        wr_count_reg;

   // Array plus data path of the pipeline. Stage 0 data is the registered
   // array read; it needs no reset because the control bits gate its use.
   // A write and a read never share a cycle, so a read one cycle after a
   // write to the same word sees the new value.
   always_ff @(posedge clk) begin
      if (mem_accept && mem.mem_write && !mem_oor) begin
         ram_reg[mem_idx] <= mem.mem_wdata;
      end else if (load_ready && !load_oor) begin
         ram_reg[load_idx] <= load_wdata;
      end
      pipe_data_reg[0] <= ram_reg[mem_idx];
      for (int i = 1; i < LATENCY; i++) begin
         pipe_data_reg[i] <= pipe_data_reg[i-1];
      end
   end

   // Read responses update the output data; write responses leave the
   // previously returned value on mem_rdata.
   logic        rsp_read;
   logic [31:0] rsp_data;
   assign rsp_read = pipe_valid_reg[LAST] & pipe_read_reg[LAST];
   assign rsp_data = pipe_zero_reg[LAST] ? 32'h0 : pipe_data_reg[LAST];

   always_ff @(posedge clk) begin
      if (reset) begin
         pipe_valid_reg <= '0;
         pipe_read_reg  <= '0;
         pipe_zero_reg  <= '0;
         rdata_hold_reg <= '0;
         err_range_reg  <= 1'b0;
         err_align_reg  <= 1'b0;
         rd_count_reg   <= '0;
         wr_count_reg   <= '0;
      end else begin
         pipe_valid_reg[0] <= mem.mem_valid;
         pipe_read_reg[0]  <= ~mem.mem_write;
         pipe_zero_reg[0]  <= mem_oor;
         for (int i = 1; i < LATENCY; i++) begin
            pipe_valid_reg[i] <= pipe_valid_reg[i-1];
            pipe_read_reg[i]  <= pipe_read_reg[i-1];
            pipe_zero_reg[i]  <= pipe_zero_reg[i-1];
         end
         if (rsp_read) begin
            rdata_hold_reg <= rsp_data;
         end
         if (mem.mem_valid) begin
            if (mem_oor)                   err_range_reg <= 1'b1;
            if (mem.mem_addr[1:0] != 2'b0) err_align_reg <= 1'b1;
            if (mem.mem_write) wr_count_reg <= wr_count_reg + 32'd1;
            else               rd_count_reg <= rd_count_reg + 32'd1;
         end
         if (load_ready) begin
            if (load_oor)               err_range_reg <= 1'b1;
            if (load_addr[1:0] != 2'b0) err_align_reg <= 1'b1;
         end
      end
   end

   assign mem.mem_ready = pipe_valid_reg[LAST];
   assign mem.mem_rdata = rsp_read ? rsp_data : rdata_hold_reg;
   assign err_range     = err_range_reg;
   assign err_align     = err_align_reg;
   assign rd_count      = rd_count_reg;
   assign wr_count      = wr_count_reg;

endmodule

// File: tb/tb_knn_mem_responder.sv
// tb_knn_mem_responder
//   Drives identical directed traffic into two responders (LATENCY 1 and 3).
//   Each request pushes its expected response cycle and data into a queue
//   per instance; a monitor per instance pops and compares on every
//   mem_ready pulse and flags responses that arrive late or unexpectedly.
module tb_knn_mem_responder;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        mem_valid = 1'b0;
   logic        mem_write = 1'b0;
   logic [31:0] mem_addr = '0;
   logic [31:0] mem_wdata = '0;
   logic        load_valid = 1'b0;
   logic [31:0] load_addr = '0;
   logic [31:0] load_wdata = '0;

   logic        load_ready1, err_range1, err_align1;
   logic [31:0] rd_count1, wr_count1;
   logic        load_ready3, err_range3, err_align3;
   logic [31:0] rd_count3, wr_count3;

   always #5 clk = ~clk;

   knn_mem_responder_if m1 ();
   knn_mem_responder_if m3 ();

   assign m1.mem_valid = mem_valid;
   assign m1.mem_write = mem_write;
   assign m1.mem_addr  = mem_addr;
   assign m1.mem_wdata = mem_wdata;
   assign m3.mem_valid = mem_valid;
   assign m3.mem_write = mem_write;
   assign m3.mem_addr  = mem_addr;
   assign m3.mem_wdata = mem_wdata;

   knn_mem_responder #(.LATENCY(1)) dut1 (
      .clk(clk), .reset(reset), .mem(m1.slave),
      .load_valid(load_valid), .load_addr(load_addr), .load_wdata(load_wdata),
      .load_ready(load_ready1), .err_range(err_range1), .err_align(err_align1),
      .rd_count(rd_count1), .wr_count(wr_count1)
   );

   knn_mem_responder #(.LATENCY(3)) dut3 (
      .clk(clk), .reset(reset), .mem(m3.slave),
      .load_valid(load_valid), .load_addr(load_addr), .load_wdata(load_wdata),
      .load_ready(load_ready3), .err_range(err_range3), .err_align(err_align3),
      .rd_count(rd_count3), .wr_count(wr_count3)
   );

   int cyc = 0;
   always @(posedge clk) cyc = cyc + 1;

   int n_checks = 0;
   int n_fail = 0;

   typedef struct {
      int          due;
      logic [31:0] data;
   } exp_t;

   exp_t        q1[$];
   exp_t        q3[$];
   logic [31:0] last_rd = '0;
   int          exp_rd = 0;
   int          exp_wr = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   // Monitor for the LATENCY=1 instance.
   always @(negedge clk) begin
      exp_t e;
      if (m1.mem_ready) begin
         if (q1.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL l1_unexpected_ready at cycle %0d: got rdata %h, expected no response", cyc, m1.mem_rdata);
         end else begin
            e = q1.pop_front();
            check("l1_ready_cycle", cyc, e.due);
            check("l1_rdata", m1.mem_rdata, e.data);
            $display("L1 response cycle %0d rdata %h", cyc, m1.mem_rdata);
         end
      end else if (q1.size() != 0 && q1[0].due <= cyc) begin
         e = q1.pop_front();
         check("l1_ready_missing", {31'b0, m1.mem_ready}, 32'd1);
      end
   end

   // Monitor for the LATENCY=3 instance.
   always @(negedge clk) begin
      exp_t e;
      if (m3.mem_ready) begin
         if (q3.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL l3_unexpected_ready at cycle %0d: got rdata %h, expected no response", cyc, m3.mem_rdata);
         end else begin
            e = q3.pop_front();
            check("l3_ready_cycle", cyc, e.due);
            check("l3_rdata", m3.mem_rdata, e.data);
            $display("L3 response cycle %0d rdata %h", cyc, m3.mem_rdata);
         end
      end else if (q3.size() != 0 && q3[0].due <= cyc) begin
         e = q3.pop_front();
         check("l3_ready_missing", {31'b0, m3.mem_ready}, 32'd1);
      end
   end

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         mem_valid  = 1'b0;
         load_valid = 1'b0;
      end
   endtask

   // One memory request; exp is the hand-computed read value (ignored for writes).
   task automatic mem_req(input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] exp);
      @(posedge clk);
      #1;
      mem_valid  = 1'b1;
      mem_write  = wr;
      mem_addr   = addr;
      mem_wdata  = wd;
      load_valid = 1'b0;
      if (!wr) last_rd = exp;
      q1.push_back('{cyc + 1, last_rd});
      q3.push_back('{cyc + 3, last_rd});
      if (wr) exp_wr++;
      else    exp_rd++;
   endtask

   task automatic load(input logic [31:0] addr, input logic [31:0] data);
      @(posedge clk);
      #1;
      mem_valid  = 1'b0;
      load_valid = 1'b1;
      load_addr  = addr;
      load_wdata = data;
      @(negedge clk);
      check("load_ready1", {31'b0, load_ready1}, 32'd1);
      check("load_ready3", {31'b0, load_ready3}, 32'd1);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      reset      = 1'b1;
      mem_valid  = 1'b0;
      load_valid = 1'b0;
      @(posedge clk);
      #1;
      q1.delete();
      q3.delete();
      last_rd = '0;
      exp_rd  = 0;
      exp_wr  = 0;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic check_zero_state();
      @(negedge clk);
      check("l1_ready_rst", {31'b0, m1.mem_ready}, 32'd0);
      check("l3_ready_rst", {31'b0, m3.mem_ready}, 32'd0);
      check("l1_rdata_rst", m1.mem_rdata, 32'd0);
      check("l3_rdata_rst", m3.mem_rdata, 32'd0);
      check("err_range1_rst", {31'b0, err_range1}, 32'd0);
      check("err_range3_rst", {31'b0, err_range3}, 32'd0);
      check("err_align1_rst", {31'b0, err_align1}, 32'd0);
      check("err_align3_rst", {31'b0, err_align3}, 32'd0);
      check("rd_count1_rst", rd_count1, 32'd0);
      check("rd_count3_rst", rd_count3, 32'd0);
      check("wr_count1_rst", wr_count1, 32'd0);
      check("wr_count3_rst", wr_count3, 32'd0);
   endtask

   task automatic check_counts(input string tag);
      @(negedge clk);
      check({tag, "_rd_count1"}, rd_count1, 32'(exp_rd));
      check({tag, "_rd_count3"}, rd_count3, 32'(exp_rd));
      check({tag, "_wr_count1"}, wr_count1, 32'(exp_wr));
      check({tag, "_wr_count3"}, wr_count3, 32'(exp_wr));
   endtask

   initial begin
      do_reset();
      check_zero_state();

      // Single preloaded read.
      load(32'h0001_0004, 32'h0000_0011);
      mem_req(1'b0, 32'h0001_0004, 32'h0, 32'h0000_0011);
      idle(5);
      check_counts("t1");

      // Back-to-back reads of preloaded words.
      load(32'h0001_0000, 32'd1);
      load(32'h0001_0004, 32'd2);
      load(32'h0001_0008, 32'd3);
      mem_req(1'b0, 32'h0001_0000, 32'h0, 32'd1);
      mem_req(1'b0, 32'h0001_0004, 32'h0, 32'd2);
      mem_req(1'b0, 32'h0001_0008, 32'h0, 32'd3);
      idle(5);

      // Write then immediate read of the same word.
      mem_req(1'b1, 32'h0001_0008, 32'hDEAD_BEEF, 32'h0);
      mem_req(1'b0, 32'h0001_0008, 32'h0, 32'hDEAD_BEEF);
      idle(5);
      check_counts("t3");

      // Address errors.
      @(negedge clk);
      check("err_range1_pre", {31'b0, err_range1}, 32'd0);
      mem_req(1'b0, 32'h0000_FFFC, 32'h0, 32'h0);
      idle(5);
      @(negedge clk);
      check("err_range1", {31'b0, err_range1}, 32'd1);
      check("err_range3", {31'b0, err_range3}, 32'd1);
      check("err_align1_pre", {31'b0, err_align1}, 32'd0);
      mem_req(1'b0, 32'h0001_0002, 32'h0, 32'd1);
      idle(5);
      @(negedge clk);
      check("err_align1", {31'b0, err_align1}, 32'd1);
      check("err_align3", {31'b0, err_align3}, 32'd1);
      check("err_range1_sticky", {31'b0, err_range1}, 32'd1);

      // Load held off while the memory port is busy.
      for (int i = 0; i < 4; i++) begin
         mem_req(1'b0, 32'h0001_0000, 32'h0, 32'd1);
         load_valid = 1'b1;
         load_addr  = 32'h0001_000C;
         load_wdata = 32'h0000_0055;
         @(negedge clk);
         check("load_blocked1", {31'b0, load_ready1}, 32'd0);
         check("load_blocked3", {31'b0, load_ready3}, 32'd0);
      end
      load(32'h0001_000C, 32'h0000_0055);
      mem_req(1'b0, 32'h0001_000C, 32'h0, 32'h0000_0055);
      idle(5);

      // Range boundary: top word valid, one past it dropped (not aliased to word 0).
      load(32'h0001_3FFC, 32'h0000_0077);
      mem_req(1'b1, 32'h0001_4000, 32'h0000_0099, 32'h0);
      mem_req(1'b0, 32'h0001_4000, 32'h0, 32'h0);
      mem_req(1'b0, 32'h0001_3FFC, 32'h0, 32'h0000_0077);
      load(32'h0001_4000, 32'h0000_00AA);
      mem_req(1'b0, 32'h0001_0000, 32'h0, 32'd1);
      idle(5);
      check_counts("t7");

      // Reset while a LATENCY=3 read is in flight.
      mem_req(1'b0, 32'h0001_0000, 32'h0, 32'd1);
      do_reset();
      check_zero_state();
      idle(4);
      mem_req(1'b0, 32'h0001_0004, 32'h0, 32'd2);
      idle(5);
      check_counts("t6");

      @(negedge clk);
      check("q1_drained", 32'(q1.size()), 32'd0);
      check("q3_drained", 32'(q3.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
